// File: rtl/srng_pkg.sv
// ============================================================================
// srng_pkg : register map, field positions and ID constants for srng_regif
// Revision : 1.0
// ============================================================================
`default_nettype none

package srng_pkg;

    localparam logic [7:0] ADDR_NAME0             = 8'h00;
    localparam logic [7:0] ADDR_NAME1             = 8'h01;
    localparam logic [7:0] ADDR_VERSION           = 8'h02;
    localparam logic [7:0] ADDR_CTRL              = 8'h08;
    localparam logic [7:0] ADDR_STATUS            = 8'h09;
    localparam logic [7:0] ADDR_NUM_DIGESTS       = 8'h0a;
    localparam logic [7:0] ADDR_NUM_SAMPLE_CYCLES = 8'h0b;
    localparam logic [7:0] ADDR_DATA              = 8'h10;

    localparam int CTRL_FLUSH_BIT   = 0;
    localparam int CTRL_CLR_ERR_BIT = 1;
    localparam int STATUS_READY_BIT = 0;
    localparam int STATUS_ERROR_BIT = 1;

    localparam logic [31:0] NAME0_VALUE   = 32'h73726e67;
    localparam logic [31:0] NAME1_VALUE   = 32'h20202020;
    localparam logic [31:0] VERSION_VALUE = 32'h302e3130;

endpackage

`default_nettype wire

// File: rtl/srng_fifo.sv
// ============================================================================
// srng_fifo : synchronous digest FIFO with push, pop, flush and level count
// Revision  : 1.0
// ============================================================================
`default_nettype none

module srng_fifo #(
    parameter int ADDR_BITS = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 push,
    input  logic [31:0]          push_data,
    input  logic                 pop,
    input  logic                 flush,
    output logic [31:0]          head,
    output logic [ADDR_BITS:0]   level,
    output logic                 full,
    output logic                 empty
);

    localparam logic [ADDR_BITS:0] DEPTH = (ADDR_BITS + 1)'(1) << ADDR_BITS;

    logic [31:0]          mem [0:(1 << ADDR_BITS) - 1];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic                 push_ok;
    logic                 pop_ok;

    assign full    = (level == DEPTH);
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage has no reset; a word written in a flush cycle is orphaned by the pointer clear.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/srng_regif.sv
// ============================================================================
// srng_regif : register-bus responder serving buffered digests and config
// Revision   : 1.0
// ============================================================================
`default_nettype none

module srng_regif
    import srng_pkg::*;
#(
    parameter int          FIFO_ADDR_BITS            = 3,
    parameter logic [7:0]  DEFAULT_NUM_DIGESTS       = 8'h10,
    parameter logic [23:0] DEFAULT_NUM_SAMPLE_CYCLES = 24'h001000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cs,
    input  logic        we,
    input  logic [7:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    input  logic [31:0] entropy_data,
    input  logic        entropy_valid,
    output logic        entropy_ready,
    output logic [7:0]  num_digests,
    output logic [23:0] num_sample_cycles
);

    logic                    rd_en;
    logic                    wr_en;
    logic                    data_rd;
    logic                    ctrl_wr;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_flush;
    logic                    empty_rd;
    logic                    error;
    logic [31:0]             head;
    logic [FIFO_ADDR_BITS:0] level;
    logic                    full;
    logic                    empty;
    logic [31:0]             status;
    logic                    unused_write_data;

    assign rd_en      = cs && !we;
    assign wr_en      = cs && we;
    assign data_rd    = rd_en && (address == ADDR_DATA);
    assign ctrl_wr    = wr_en && (address == ADDR_CTRL);
    assign fifo_push  = entropy_valid && !full;
    assign fifo_pop   = data_rd && !empty;
    assign fifo_flush = ctrl_wr && write_data[CTRL_FLUSH_BIT];
    assign empty_rd   = data_rd && empty;

    assign entropy_ready     = !full;
    assign unused_write_data = ^write_data[31:24];

    srng_fifo #(
        .ADDR_BITS (FIFO_ADDR_BITS)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (fifo_push),
        .push_data (entropy_data),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (head),
        .level     (level),
        .full      (full),
        .empty     (empty)
    );

    // Sticky error: a same-cycle empty DATA read overrides the clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            error <= 1'b0;
        end else if (empty_rd) begin
            error <= 1'b1;
        end else if (ctrl_wr && write_data[CTRL_CLR_ERR_BIT]) begin
            error <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            num_digests       <= DEFAULT_NUM_DIGESTS;
            num_sample_cycles <= DEFAULT_NUM_SAMPLE_CYCLES;
        end else if (wr_en) begin
            if (address == ADDR_NUM_DIGESTS) begin
                num_digests <= write_data[7:0];
            end
            if (address == ADDR_NUM_SAMPLE_CYCLES) begin
                num_sample_cycles <= write_data[23:0];
            end
        end
    end

    always_comb begin
        status                   = '0;
        status[STATUS_READY_BIT] = !empty;
        status[STATUS_ERROR_BIT] = error;
        status[15:8]             = 8'(level);
    end

    always_comb begin
        read_data = '0;
        if (rd_en) begin
            case (address)
                ADDR_NAME0:             read_data = NAME0_VALUE;
                ADDR_NAME1:             read_data = NAME1_VALUE;
                ADDR_VERSION:           read_data = VERSION_VALUE;
                ADDR_STATUS:            read_data = status;
                ADDR_NUM_DIGESTS:       read_data = {24'h0, num_digests};
                ADDR_NUM_SAMPLE_CYCLES: read_data = {8'h0, num_sample_cycles};
                ADDR_DATA:              read_data = empty ? 32'h0 : head;
                default:                read_data = '0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_srng_regif.sv
// ============================================================================
// tb_srng_regif : directed and random bus/entropy traffic against a queue model
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_srng_regif;

    logic        clk;
    logic        reset_n;
    logic        cs;
    logic        we;
    logic [7:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic [31:0] entropy_data;
    logic        entropy_valid;
    logic        entropy_ready;
    logic [7:0]  num_digests;
    logic [23:0] num_sample_cycles;

    int n_checks;
    int n_fail;

    // Reference model: digest queue, sticky error, config registers.
    logic [31:0] mq [$];
    bit          merr;
    logic [7:0]  mnd;
    logic [23:0] mnsc;

    logic [7:0] addr_tab [0:8] = '{8'h00, 8'h01, 8'h02, 8'h08, 8'h09,
                                    8'h0a, 8'h0b, 8'h10, 8'h10};

    srng_regif dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .cs                (cs),
        .we                (we),
        .address           (address),
        .write_data        (write_data),
        .read_data         (read_data),
        .entropy_data      (entropy_data),
        .entropy_valid     (entropy_valid),
        .entropy_ready     (entropy_ready),
        .num_digests       (num_digests),
        .num_sample_cycles (num_sample_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        merr = 1'b0;
        mnd  = 8'h10;
        mnsc = 24'h001000;
    endtask

    function automatic logic [31:0] model_rd(logic c, logic w, logic [7:0] a);
        if (!c || w) return 32'h0;
        case (a)
            8'h00: return 32'h73726e67;
            8'h01: return 32'h20202020;
            8'h02: return 32'h302e3130;
            8'h09: return {16'h0, 8'(mq.size()), 6'b0, merr, mq.size() != 0};
            8'h0a: return {24'h0, mnd};
            8'h0b: return {8'h0, mnsc};
            8'h10: return (mq.size() != 0) ? mq[0] : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    // Advance one clock, apply the architectural effect of the current inputs
    // to the model, then check the always-visible outputs.
    task automatic tick();
        bit          do_push, do_pop, emp_rd, wr;
        logic [7:0]  a;
        logic [31:0] wd, ed, tmp;
        do_push = entropy_valid && (mq.size() < 8);
        do_pop  = cs && !we && (address == 8'h10) && (mq.size() > 0);
        emp_rd  = cs && !we && (address == 8'h10) && (mq.size() == 0);
        wr      = cs && we;
        a       = address;
        wd      = write_data;
        ed      = entropy_data;
        @(posedge clk);
        if (wr && a == 8'h08 && wd[0]) begin
            mq.delete();
        end else begin
            if (do_pop) tmp = mq.pop_front();
            if (do_push) mq.push_back(ed);
        end
        if (wr && a == 8'h08 && wd[1]) merr = 1'b0;
        if (emp_rd) merr = 1'b1;
        if (wr && a == 8'h0a) mnd = wd[7:0];
        if (wr && a == 8'h0b) mnsc = wd[23:0];
        #1;
        check("entropy_ready", {31'h0, entropy_ready}, {31'h0, mq.size() < 8});
        check("num_digests", {24'h0, num_digests}, {24'h0, mnd});
        check("num_sample_cycles", {8'h0, num_sample_cycles}, {8'h0, mnsc});
    endtask

    task automatic rd_const(input string tag, input logic [7:0] a, input logic [31:0] exp);
        cs = 1'b1; we = 1'b0; address = a;
        #1;
        check(tag, read_data, exp);
        tick();
        cs = 1'b0;
    endtask

    task automatic rd_model(input string tag, input logic [7:0] a);
        cs = 1'b1; we = 1'b0; address = a;
        #1;
        check(tag, read_data, model_rd(1'b1, 1'b0, a));
        tick();
        cs = 1'b0;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
        cs = 1'b1; we = 1'b1; address = a; write_data = d;
        tick();
        cs = 1'b0; we = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d);
        entropy_valid = 1'b1; entropy_data = d;
        tick();
        entropy_valid = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset_n = 1'b0;
        cs = 1'b0; we = 1'b0; address = 8'h0; write_data = 32'h0;
        entropy_valid = 1'b0; entropy_data = 32'h0;
        model_reset();
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset state and ID registers
        check("ready_after_reset", {31'h0, entropy_ready}, 32'h1);
        rd_const("name0", 8'h00, 32'h73726e67);
        rd_const("version", 8'h02, 32'h302e3130);
        rd_const("num_digests_rst", 8'h0a, 32'h10);
        rd_const("num_sample_rst", 8'h0b, 32'h1000);
        rd_const("status_rst", 8'h09, 32'h0);
        rd_const("ctrl_reads_zero", 8'h08, 32'h0);
        rd_const("unmapped", 8'h55, 32'h0);

        // Two pushes, then drain in order
        push_word(32'hdeadbeef);
        push_word(32'h01234567);
        rd_const("status_two", 8'h09, 32'h00000201);
        rd_const("data0", 8'h10, 32'hdeadbeef);
        rd_const("data1", 8'h10, 32'h01234567);
        rd_const("status_drained", 8'h09, 32'h0);

        // Fill to full; a held ninth word waits for a pop
        for (int i = 0; i < 8; i++) push_word($urandom);
        check("ready_full", {31'h0, entropy_ready}, 32'h0);
        rd_const("status_full", 8'h09, 32'h00000801);
        entropy_valid = 1'b1; entropy_data = 32'hcafef00d;
        repeat (3) tick();
        check("ninth_held", {31'h0, entropy_ready}, 32'h0);
        cs = 1'b1; we = 1'b0; address = 8'h10;
        #1;
        check("pop_when_full", read_data, model_rd(1'b1, 1'b0, 8'h10));
        tick();
        cs = 1'b0;
        check("ready_after_pop", {31'h0, entropy_ready}, 32'h1);
        tick();
        entropy_valid = 1'b0;
        rd_const("status_refull", 8'h09, 32'h00000801);
        for (int i = 0; i < 7; i++) rd_model("drain", 8'h10);
        rd_const("ninth_last", 8'h10, 32'hcafef00d);

        // Empty read sets sticky error; CTRL clears it
        rd_const("data_empty", 8'h10, 32'h0);
        rd_const("status_err", 8'h09, 32'h00000002);
        bus_wr(8'h08, 32'h2);
        rd_const("status_clr", 8'h09, 32'h0);
        cs = 1'b1; we = 1'b0; address = 8'h10;
        tick();
        cs = 1'b1; we = 1'b1; address = 8'h08; write_data = 32'h2;
        tick();
        cs = 1'b0; we = 1'b0;
        rd_const("status_clr_only", 8'h09, 32'h0);

        // Simultaneous push and pop at level 4
        for (int i = 0; i < 4; i++) push_word(32'h1000 + i);
        cs = 1'b1; we = 1'b0; address = 8'h10;
        entropy_valid = 1'b1; entropy_data = 32'h00abcd00;
        #1;
        check("pushpop_head", read_data, 32'h1000);
        tick();
        cs = 1'b0; entropy_valid = 1'b0;
        rd_const("status_level4", 8'h09, 32'h00000401);
        for (int i = 0; i < 4; i++) rd_model("order", 8'h10);

        // Flush wins over a same-cycle push
        push_word(32'h11111111);
        push_word(32'h22222222);
        entropy_valid = 1'b1; entropy_data = 32'h33333333;
        bus_wr(8'h08, 32'h1);
        entropy_valid = 1'b0;
        rd_const("status_flushed", 8'h09, 32'h0);

        // Config writes and ignored read-only writes
        bus_wr(8'h0b, 32'hffabcdef);
        check("nsc_write", {8'h0, num_sample_cycles}, 32'h00abcdef);
        bus_wr(8'h0a, 32'h1234565a);
        check("nd_write", {24'h0, num_digests}, 32'h5a);
        bus_wr(8'h09, 32'hffffffff);
        bus_wr(8'h00, 32'h0);
        rd_const("status_ro", 8'h09, 32'h0);
        rd_const("name0_ro", 8'h00, 32'h73726e67);

        // Asynchronous reset mid-fill
        for (int i = 0; i < 3; i++) push_word($urandom);
        entropy_valid = 1'b1; entropy_data = 32'h77777777;
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        entropy_valid = 1'b0;
        cs = 1'b1; we = 1'b0; address = 8'h09;
        #1;
        check("status_in_reset", read_data, 32'h0);
        check("ready_in_reset", {31'h0, entropy_ready}, 32'h1);
        check("nd_in_reset", {24'h0, num_digests}, 32'h10);
        reset_n = 1'b1;
        cs = 1'b0;
        tick();
        rd_const("status_post_reset", 8'h09, 32'h0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            int r;
            r  = int'($urandom_range(0, 99));
            cs = (r < 60);
            we = (r < 6);
            address = ($urandom_range(0, 9) == 0) ? 8'($urandom) : addr_tab[$urandom_range(0, 8)];
            write_data = $urandom;
            if (!(entropy_valid && !entropy_ready)) begin
                entropy_valid = ($urandom_range(0, 2) != 0);
                entropy_data  = $urandom;
            end
            #1;
            check("rand_read", read_data, model_rd(cs, we, address));
            tick();
        end
        cs = 1'b0; we = 1'b0; entropy_valid = 1'b0;
        rd_model("rand_status", 8'h09);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
